// File: rtl/cd_frame_ring.sv
// cd_frame_ring: multi-slot frame buffer between the CDBUS byte engines and the host.
// The writer fills and commits whole slots with flags/length. The reader consumes and releases them in order.
module cd_frame_ring #(
    parameter int D_WIDTH   = 8,
    parameter int A_WIDTH   = 8,
    parameter int N_WIDTH   = 2,
    parameter int F_WIDTH   = 8,
    parameter int OVERWRITE = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic               wr_en,
    input  logic               wr_commit,
    input  logic [F_WIDTH-1:0] wr_flags,
    input  logic [A_WIDTH:0]   wr_len,
    output logic               wr_full,
    output logic               commit_fail,
    output logic               commit_drop,
    output logic [7:0]         fail_cnt,
    output logic [D_WIDTH-1:0] rd_data,
    input  logic [A_WIDTH-1:0] rd_addr,
    input  logic               rd_en,
    input  logic               rd_done,
    input  logic               rd_flush,
    output logic               rd_valid,
    output logic [F_WIDTH-1:0] rd_flags,
    output logic [A_WIDTH:0]   rd_len,
    output logic [N_WIDTH-1:0] frame_cnt
);
    localparam int N     = 1 << N_WIDTH;
    localparam int DEPTH = 1 << A_WIDTH;
    localparam bit OW    = (OVERWRITE != 0);

    logic [D_WIDTH-1:0] ram        [N*DEPTH];
    logic [F_WIDTH-1:0] meta_flags [N];
    logic [A_WIDTH:0]   meta_len   [N];

    logic [N_WIDTH-1:0] wr_sel, rd_sel, wr_next;
    logic [N_WIDTH-1:0] wr_sel_d, rd_sel_d;
    logic [N-1:0]       dirty, dirty_d;
    logic               do_release, freed, full_commit;
    logic               do_commit, do_drop, do_fail;

    assign wr_next  = wr_sel + N_WIDTH'(1);
    assign rd_valid = dirty[rd_sel];
    assign wr_full  = dirty[wr_next];
    assign rd_flags = meta_flags[rd_sel];
    assign rd_len   = meta_len[rd_sel];

    // A full buffer can only be holding the reader's slot at wr_sel+1, so releasing it frees room.
    assign do_release  = rd_done && rd_valid;
    assign freed       = do_release && (rd_sel == wr_next);
    assign full_commit = wr_commit && wr_full && !freed;
    assign do_commit   = !rd_flush && wr_commit && (!wr_full || freed || OW);
    assign do_drop     = !rd_flush && full_commit && OW;
    assign do_fail     = !rd_flush && full_commit && !OW;

    always_comb begin
        wr_sel_d = wr_sel;
        rd_sel_d = rd_sel;
        dirty_d  = dirty;
        if (do_release || do_drop) begin
            dirty_d[rd_sel] = 1'b0;
            rd_sel_d        = rd_sel + N_WIDTH'(1);
        end
        if (do_commit) begin
            dirty_d[wr_sel] = 1'b1;
            wr_sel_d        = wr_next;
        end
        if (rd_flush) begin
            wr_sel_d = '0;
            rd_sel_d = '0;
            dirty_d  = '0;
        end
    end

    always_comb begin
        frame_cnt = '0;
        for (int i = 0; i < N; i++) begin
            frame_cnt = frame_cnt + N_WIDTH'(dirty[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_sel      <= '0;
            rd_sel      <= '0;
            dirty       <= '0;
            commit_fail <= 1'b0;
            commit_drop <= 1'b0;
            fail_cnt    <= '0;
            rd_data     <= '0;
        end else begin
            wr_sel      <= wr_sel_d;
            rd_sel      <= rd_sel_d;
            dirty       <= dirty_d;
            commit_fail <= do_fail;
            commit_drop <= do_drop;
            if ((do_fail || do_drop) && fail_cnt != 8'hFF) begin
                fail_cnt <= fail_cnt + 8'd1;
            end
            if (rd_en) begin
                rd_data <= ram[{rd_sel, rd_addr}];
            end
        end
    end

    // Payload and meta storage are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[{wr_sel, wr_addr}] <= wr_data;
        end
        if (do_commit) begin
            meta_flags[wr_sel] <= wr_flags;
            meta_len[wr_sel]   <= wr_len;
        end
    end
endmodule

// File: doc/cd_frame_ring.md
Name: cd_frame_ring

Overview:
- Multi-slot frame buffer between the CDBUS RX/TX byte engines and the host register interface.
- Writer fills the current write slot by address, then commits it with flags and length. Reader consumes committed frames in order, by address, then releases each one.
- Generalised in data width, slot count and flag width. Adds per-frame length, a frame count, early-full indication, an optional overwrite-oldest mode, and a saturating commit-failure counter.

Parameters:
- D_WIDTH, 8: data word width.
- A_WIDTH, 8: address width inside one slot; slot depth = 2**A_WIDTH words.
- N_WIDTH, 2: slot index width; N = 2**N_WIDTH slots, N >= 2. Up to N-1 committed frames are held.
- F_WIDTH, 8: per-frame flags width.
- OVERWRITE, 0: 0 = commit fails when full; 1 = commit drops the oldest unread frame when full.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: synchronous active-low reset.
- wr_data, in, D_WIDTH: write word.
- wr_addr, in, A_WIDTH: write address within the current write slot.
- wr_en, in, 1: write strobe.
- wr_commit, in, 1: commit the current write slot.
- wr_flags, in, F_WIDTH: flags stored at commit.
- wr_len, in, A_WIDTH+1: frame length stored at commit.
- wr_full, out, 1: next write slot holds an unread frame.
- commit_fail, out, 1: one-cycle pulse, commit refused.
- commit_drop, out, 1: one-cycle pulse, oldest frame discarded (OVERWRITE=1 only).
- fail_cnt, out, 8: saturating count of commit_fail plus commit_drop events.
- rd_data, out, D_WIDTH: read word, registered.
- rd_addr, in, A_WIDTH: read address within the current read slot.
- rd_en, in, 1: read strobe.
- rd_done, in, 1: release the current read frame.
- rd_flush, in, 1: discard everything and return to the empty state.
- rd_valid, out, 1: the current read slot holds a committed frame.
- rd_flags, out, F_WIDTH: flags of the current read slot.
- rd_len, out, A_WIDTH+1: length of the current read slot.
- frame_cnt, out, N_WIDTH: number of committed unread frames (0..N-1).

Behaviour:
- State:
  - wr_sel and rd_sel are N_WIDTH-bit indices that wrap modulo N.
  - dirty is an N-bit vector; frame_cnt = popcount(dirty).
  - Per-slot meta registers hold flags and len.
  - The slot at wr_sel is never dirty.
- Reset (reset_n low at a clk edge):
  - wr_sel = rd_sel = 0, dirty = 0, fail_cnt = 0.
  - commit_fail = commit_drop = 0; rd_data = 0.
  - RAM and meta contents are not reset.
- Write:
  - wr_en writes wr_data into ram[wr_sel][wr_addr] at the clock edge.
  - A write in the same cycle as wr_commit lands in the pre-commit slot.
- Read:
  - rd_en loads rd_data from ram[rd_sel][rd_addr] at the edge: 1-cycle latency.
  - rd_data holds its value while rd_en is low.
  - Reads of a non-dirty slot return undefined data.
- rd_flags and rd_len are combinational from meta[rd_sel]. rd_valid = dirty[rd_sel]. wr_full = dirty[wr_sel+1].
- Evaluation order: all conditions below use pre-edge state.
- Release:
  - rd_done && rd_valid: clear dirty[rd_sel], rd_sel += 1.
  - rd_done && !rd_valid: ignored.
- Commit, free case:
  - Condition: !wr_full, or (rd_done && rd_valid && rd_sel == wr_sel+1).
  - Action: set dirty[wr_sel], store meta[wr_sel] = {wr_flags, wr_len}, wr_sel += 1.
- Commit, full case with OVERWRITE=0 (full and not freed this cycle):
  - Nothing changes except a 1-cycle commit_fail pulse.
  - The writer keeps the same slot and may retry.
- Commit, full case with OVERWRITE=1:
  - Clear dirty[rd_sel] (rd_sel == wr_sel+1 necessarily) and rd_sel += 1.
  - Then perform the normal commit.
  - Pulse commit_drop for 1 cycle.
  - rd_sel advances exactly once even if rd_done is also asserted.
- fail_cnt increments on each commit_fail or commit_drop pulse and saturates at 255. It is cleared only by reset.
- rd_flush:
  - Highest priority: wr_sel = rd_sel = 0, dirty = 0.
  - A coincident commit or rd_done is discarded; no fail or drop pulse that cycle.
  - A coincident wr_en still writes slot wr_sel (pre-flush index).
- Pulses commit_fail and commit_drop are registered and default to 0 every cycle.

Test Plan (N_WIDTH=2, OVERWRITE=0 unless stated):
- Reset, write 0xA5 at addr 3, commit with flags=0x11, len=4.
  - Required: next cycle rd_valid=1, rd_flags=0x11, rd_len=4, frame_cnt=1.
  - rd_en at addr 3 gives rd_data=0xA5 one cycle later.
- Commit 3 frames with no reads.
  - Required: frame_cnt=3, wr_full=1.
  - A 4th commit pulses commit_fail, fail_cnt=1, and all state is unchanged.
- Full buffer, assert commit and rd_done in the same cycle.
  - Required: commit succeeds, frame_cnt stays 3, no fail pulse, rd_flags shows the second frame.
- OVERWRITE=1, full buffer holding flags 1, 2, 3, commit flags 4.
  - Required: commit_drop pulses, rd_flags=2, frame_cnt=3.
  - Draining yields flags 2, 3, 4.
- Commit 2 frames, then assert rd_flush together with a commit.
  - Required: frame_cnt=0, rd_valid=0, wr_sel=rd_sel=0, no pulses.
  - rd_done on the empty buffer is ignored.
- Hold 300 fail events (OVERWRITE=0, full).
  - Required: fail_cnt saturates at 255.
  - Reset asserted mid-sequence clears it to 0 at the next edge.
